control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 49 ++++
 rtl/control_unit.sv | 128 ++++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the single-bus control unit:
// state encoding, opcodes, IR field bounds and the strobe bundle.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_LD   = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_JMP  = 5'd3;
    localparam logic [4:0] OP_HALT = 5'd4;

    localparam int IR_OP_HI   = 31;
    localparam int IR_OP_LO   = 27;
    localparam int IR_ADDR_HI = 22;
    localparam int IR_ADDR_LO = 0;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_LD0  = 4'd5,
        S_LD1  = 4'd6,
        S_LD2  = 4'd7,
        S_ST0  = 4'd8,
        S_ST1  = 4'd9,
        S_ST2  = 4'd10,
        S_J0   = 4'd11,
        S_HALT = 4'd12
    } state_e;

    typedef struct packed {
        logic pco;
        logic iro;
        logic maro;
        logic mdro;
        logic r0o;
        logic pcin;
        logic irin;
        logic marin;
        logic mdrin;
        logic r0in;
        logic inc_pc;
        logic mdr_sel_mem;
        logic mem_rd;
        logic mem_wr;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: maps the sequencer state to its strobe bundle.
// Purely combinational; at most one bus source is raised per state.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_F0: begin
                ctrl_o.pco    = 1'b1;
                ctrl_o.marin  = 1'b1;
                ctrl_o.inc_pc = 1'b1;
            end
            S_F1, S_LD1: begin
                ctrl_o.mem_rd      = 1'b1;
                ctrl_o.mdrin       = 1'b1;
                ctrl_o.mdr_sel_mem = 1'b1;
            end
            S_F2: begin
                ctrl_o.mdro = 1'b1;
                ctrl_o.irin = 1'b1;
            end
            S_LD0, S_ST0: begin
                ctrl_o.iro   = 1'b1;
                ctrl_o.marin = 1'b1;
            end
            S_LD2: begin
                ctrl_o.mdro = 1'b1;
                ctrl_o.r0in = 1'b1;
            end
            S_ST1: begin
                ctrl_o.r0o   = 1'b1;
                ctrl_o.mdrin = 1'b1;
            end
            S_ST2: ctrl_o.mem_wr = 1'b1;
            S_J0: begin
                ctrl_o.iro  = 1'b1;
                ctrl_o.pcin = 1'b1;
            end
            S_HALT: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetch, decode and LD/ST/JMP/HALT execute,
// stalling on the memory req/ack handshake; counts retired instructions.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_ack,
    output logic            pco,
    output logic            iro,
    output logic            maro,
    output logic            mdro,
    output logic            r0o,
    output logic            pcin,
    output logic            irin,
    output logic            marin,
    output logic            mdrin,
    output logic            r0in,
    output logic            inc_pc,
    output logic            mdr_sel_mem,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    state_e          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            retire;
    logic [OPW-1:0]  op;
    logic            ir_unused;
    ctrl_t           ctrl;

    assign op        = ir[IR_OP_HI -: OPW];
    assign ir_unused = ^{ir[IR_OP_LO-1:IR_ADDR_HI+1],
                         ir[IR_ADDR_HI:IR_ADDR_LO]};

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   if (mem_ack) state_d = S_F2;
            S_F2:   state_d = S_DEC;
            S_DEC: begin
                if (op == OPW'(OP_LD)) begin
                    state_d = S_LD0;
                end else if (op == OPW'(OP_ST)) begin
                    state_d = S_ST0;
                end else if (op == OPW'(OP_JMP)) begin
                    state_d = S_J0;
                    retire  = 1'b1;
                end else if (op == OPW'(OP_HALT)) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    // undefined opcodes retire as NOP but stay flagged
                    if (op != OPW'(OP_NOP)) illegal_d = 1'b1;
                    state_d = S_F0;
                    retire  = 1'b1;
                end
            end
            S_LD0:  state_d = S_LD1;
            S_LD1:  if (mem_ack) state_d = S_LD2;
            S_LD2: begin
                state_d = S_F0;
                retire  = 1'b1;
            end
            S_ST0:  state_d = S_ST1;
            S_ST1:  state_d = S_ST2;
            S_ST2: begin
                if (mem_ack) begin
                    state_d = S_F0;
                    retire  = 1'b1;
                end
            end
            S_J0:   state_d = S_F0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        cnt_d = cnt_q + CNTW'(retire);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign pco         = ctrl.pco;
    assign iro         = ctrl.iro;
    assign maro        = ctrl.maro;
    assign mdro        = ctrl.mdro;
    assign r0o         = ctrl.r0o;
    assign pcin        = ctrl.pcin;
    assign irin        = ctrl.irin;
    assign marin       = ctrl.marin;
    assign mdrin       = ctrl.mdrin;
    assign r0in        = ctrl.r0in;
    assign inc_pc      = ctrl.inc_pc;
    assign mdr_sel_mem = ctrl.mdr_sel_mem;
    assign mem_rd      = ctrl.mem_rd;
    assign mem_wr      = ctrl.mem_wr;
    assign halted      = ctrl.halted;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction table with a
// scoreboard queue plus hand-written HALT and clear sequences.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, run, mem_ack;
    logic [31:0] ir;
    logic        pco, iro, maro, mdro, r0o;
    logic        pcin, irin, marin, mdrin, r0in;
    logic        inc_pc, mdr_sel_mem, mem_rd, mem_wr;
    logic        halted, illegal;
    logic [15:0] instr_count;

    control_unit #(.OPW(5), .CNTW(16)) dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .ir          (ir),
        .mem_ack     (mem_ack),
        .pco         (pco),
        .iro         (iro),
        .maro        (maro),
        .mdro        (mdro),
        .r0o         (r0o),
        .pcin        (pcin),
        .irin        (irin),
        .marin       (marin),
        .mdrin       (mdrin),
        .r0in        (r0in),
        .inc_pc      (inc_pc),
        .mdr_sel_mem (mdr_sel_mem),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          fw;
        int          ew;
        int          len;
        int          dcnt;
        int          rdx;
        int          wrc;
        int          r0in_c;
        int          stpair;
        int          jpair;
        logic        ill;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];

    int          fw_v, ew_v, waits_left;
    bit          exec_ph, manual;
    logic [31:0] next_instr;
    int          rdx_c, wr_c, r0in_c, stpair_c, jpair_c;

    function automatic logic [15:0] outs();
        return {pco, iro, maro, mdro, r0o, pcin, irin, marin, mdrin,
                r0in, inc_pc, mdr_sel_mem, mem_rd, mem_wr, halted, illegal};
    endfunction

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // one clock: sample outputs after the edge, model IR and memory
    task automatic step();
        @(posedge clock);
        #1;
        checks++;
        if ($countones({pco, iro, maro, mdro, r0o}) > 1) begin
            failures++;
            $display("FAIL bus_onehot got=%b exp=<=1 hot",
                     {pco, iro, maro, mdro, r0o});
        end
        if (irin) begin
            ir = next_instr;
            exec_ph = 1'b1;
        end
        if (pco) exec_ph = 1'b0;
        if (exec_ph && mem_rd) rdx_c++;
        if (mem_wr) wr_c++;
        if (r0in) r0in_c++;
        if (r0o && mdrin && !mdr_sel_mem) stpair_c++;
        if (iro && pcin) jpair_c++;
        if (!manual) begin
            if (mem_rd || mem_wr) begin
                if (waits_left == 0) begin
                    mem_ack = 1'b1;
                end else begin
                    mem_ack = 1'b0;
                    waits_left--;
                end
            end else begin
                mem_ack = 1'b0;
                waits_left = exec_ph ? ew_v : fw_v;
            end
        end
    endtask

    // starts with the DUT sampled in F0; ends at the next F0
    task automatic run_instr(vec_t v);
        vec_t        e;
        int          n;
        logic [15:0] c0;
        sb.push_back(v);
        fw_v = v.fw;
        ew_v = v.ew;
        waits_left = v.fw;
        next_instr = v.instr;
        rdx_c = 0; wr_c = 0; r0in_c = 0; stpair_c = 0; jpair_c = 0;
        c0 = instr_count;
        n = 0;
        do begin
            step();
            n++;
        end while (!pco && n < 60);
        e = sb.pop_front();
        check({e.name, "_len"}, n, e.len);
        check({e.name, "_cnt"}, 16'(instr_count - c0), e.dcnt);
        check({e.name, "_rdx"}, rdx_c, e.rdx);
        check({e.name, "_wr"}, wr_c, e.wrc);
        check({e.name, "_r0in"}, r0in_c, e.r0in_c);
        check({e.name, "_st1"}, stpair_c, e.stpair);
        check({e.name, "_j0"}, jpair_c, e.jpair);
        check({e.name, "_ill"}, illegal, e.ill);
    endtask

    initial begin
        vec_t        tbl[13];
        int          n;
        logic [15:0] c0;

        tbl[0]  = '{"nop0", 32'h0000_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b0};
        tbl[1]  = '{"nop1", 32'h0000_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b0};
        tbl[2]  = '{"nop2", 32'h0000_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b0};
        tbl[3]  = '{"ld_w0", 32'h0800_0010, 0, 0, 7, 1, 1, 0, 1, 0, 0, 1'b0};
        tbl[4]  = '{"ld_w2", 32'h0800_0010, 0, 2, 9, 1, 3, 0, 1, 0, 0, 1'b0};
        tbl[5]  = '{"st_w0", 32'h1000_0020, 0, 0, 7, 1, 0, 1, 0, 1, 0, 1'b0};
        tbl[6]  = '{"st_w1", 32'h1000_0020, 0, 1, 8, 1, 0, 2, 0, 1, 0, 1'b0};
        tbl[7]  = '{"jmp", 32'h1800_0005, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1'b0};
        tbl[8]  = '{"nop_fw2", 32'h0000_0000, 2, 0, 6, 1, 0, 0, 0, 0, 0, 1'b0};
        tbl[9]  = '{"illop", 32'hF800_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b1};
        tbl[10] = '{"ld_fw1", 32'h0800_0010, 1, 1, 9, 1, 2, 0, 1, 0, 0, 1'b1};
        tbl[11] = '{"jmp2", 32'h1800_0005, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1'b1};
        tbl[12] = '{"nop_end", 32'h0000_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b1};

        clear = 1'b1; run = 1'b0; mem_ack = 1'b0; ir = '0;
        manual = 1'b0; exec_ph = 1'b0;
        fw_v = 0; ew_v = 0; waits_left = 0; next_instr = '0;
        step();
        step();
        check("reset_outs", outs(), 16'h0000);
        check("reset_cnt", instr_count, 0);
        clear = 1'b0;
        step();
        check("idle_outs", outs(), 16'h0000);
        run = 1'b1;
        step();
        check("f0_outs", outs(), 16'h8120);

        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i]);
            if (i == 2) check("nop_stream_cnt", instr_count, 3);
        end
        check("table_cnt", instr_count, 13);

        // HALT: four cycles from F0, then frozen regardless of run
        next_instr = 32'h2000_0000;
        c0 = instr_count;
        n = 0;
        do begin
            step();
            n++;
        end while (!halted && n < 20);
        check("halt_len", n, 4);
        check("halt_cnt", 16'(instr_count - c0), 1);
        check("halt_outs", outs(), 16'h0003);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            step();
            check("halt_hold", outs(), 16'h0003);
        end
        check("halt_cnt_hold", 16'(instr_count - c0), 1);

        clear = 1'b1;
        run = 1'b0;
        step();
        check("clr_halt_outs", outs(), 16'h0000);
        check("clr_halt_cnt", instr_count, 0);
        clear = 1'b0;
        run = 1'b1;
        step();
        check("restart_f0", outs(), 16'h8120);
        run = 1'b0;
        run_instr('{"nop_re", 32'h0000_0000, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1'b0});
        check("pre_clr_cnt", instr_count, 1);

        // clear collides with ack during the fetch read
        manual = 1'b1;
        mem_ack = 1'b0;
        step();
        check("f1_rd", mem_rd, 1);
        step();
        check("f1_wait_rd", mem_rd, 1);
        mem_ack = 1'b1;
        clear = 1'b1;
        step();
        check("clr_f1_outs", outs(), 16'h0000);
        check("clr_f1_cnt", instr_count, 0);
        mem_ack = 1'b0;
        clear = 1'b0;
        step();
        check("post_clr_idle", outs(), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
